bbox_overlay_ctrl: RTL and testbench
====================================

Name: bbox_overlay_ctrl

Overview:
Per-frame controller that feeds the VGA overlay stage its bounding box (x_min/x_max/y_min/y_max) and its recognised-class index (out_a).
- Scans the binary detection mask stream and accumulates min/max coordinates of hit pixels over one frame.
- Commits the box once per frame, at frame end, so the display never sees a half-updated box.
- Debounces the class result across frames before presenting it to the display.

Parameters:
H_DISP, 640, active pixels per line; the x range is 0..H_DISP-1.
V_DISP, 480, active lines per frame; the y range is 0..V_DISP-1.
MIN_HITS, 64, minimum hit-pixel count for a valid box.
HIT_CNT_W, 20, width of the hit counter (saturating).
STABLE_FRAMES, 3, consecutive identical class frames required before out_a changes (range 1..15).
MARGIN, 4, box expansion in pixels; used only with BBOX_MARGIN_EN.

Ports:
clk  in  1  pixel clock (25 MHz).
rst_n  in  1  asynchronous active-low reset.
frame_start  in  1  1-cycle pulse coincident with the first active pixel of a frame.
frame_end  in  1  1-cycle pulse after the last active pixel, inside vertical blanking.
pix_valid  in  1  active-pixel qualifier.
pix_hit  in  1  mask bit for the current pixel.
lcd_x  in  12  current pixel x.
lcd_y  in  12  current pixel y.
class_valid  in  1  1-cycle pulse: class_in is valid.
class_in  in  4  recognised class, 0..7.
x_min  out  12  committed box left.
x_max  out  12  committed box right.
y_min  out  12  committed box top.
y_max  out  12  committed box bottom.
box_valid  out  1  committed box meets MIN_HITS.
out_a  out  4  debounced class index.
upd_pulse  out  1  1-cycle pulse, high in the cycle the committed outputs change.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; x_min=x_max=y_min=y_max=12'hFFF; box_valid=0; out_a=4'd0; upd_pulse=0; all accumulators, hit count, candidate and stable count cleared.
- FSM has three states: IDLE, ACCUM, COMMIT.
  - IDLE -> ACCUM on frame_start.
  - ACCUM -> COMMIT on frame_end.
  - COMMIT -> IDLE after exactly 1 cycle.
  - frame_end while in IDLE or COMMIT: ignored.
  - frame_start while in ACCUM (frame_end was missed): restart accumulation and stay in ACCUM; nothing is committed.
- On frame_start, accumulators initialise: xmin_acc=H_DISP-1, xmax_acc=0, ymin_acc=V_DISP-1, ymax_acc=0, hit_cnt=0, class_seen=0.
  - If pix_valid&pix_hit is asserted in the frame_start cycle, that pixel is included: the accumulators load its coordinates and hit_cnt=1.
- ACCUM pixel update, when pix_valid&pix_hit and lcd_x<H_DISP and lcd_y<V_DISP:
  - xmin_acc=min(xmin_acc, lcd_x); xmax_acc=max(xmax_acc, lcd_x); likewise for y.
  - hit_cnt increments and saturates at 2^HIT_CNT_W-1.
  - Out-of-range coordinates are ignored.
- Class capture (any state): class_valid with class_in<=7 latches cand_new=class_in and sets class_seen=1. Last pulse in a frame wins. class_in>7 is ignored.
- COMMIT cycle; registered outputs update on the next edge, together with upd_pulse=1 for 1 cycle:
  - Box: if hit_cnt>=MIN_HITS, x_min..y_max take the accumulator values and box_valid=1. Otherwise all four become 12'hFFF (nothing drawn) and box_valid=0.
  - Class, if class_seen and cand_new==cand_prev: stable_cnt=min(stable_cnt+1, 15).
  - Class, if class_seen and cand_new differs: stable_cnt=1 and cand_prev=cand_new.
  - Class, if !class_seen: stable_cnt=0; out_a holds.
  - When the new stable_cnt>=STABLE_FRAMES, out_a=cand_prev.
- Latency: committed outputs are valid 2 cycles after frame_end. They are stable for the whole next frame.
- Committed outputs change only on the COMMIT edge, never mid-frame.
- Reset mid-frame returns to the reset values. The next frame_start begins cleanly; the partial frame is never committed.

Optional Feature:
BBOX_MARGIN_EN
- Defined: at COMMIT (valid box only), x_min=max(xmin_acc-MARGIN, 0), x_max=min(xmax_acc+MARGIN, H_DISP-1), and likewise for y with V_DISP-1. Use signed/extended arithmetic; no wrap-around.
- Undefined: raw accumulator values are committed and the margin logic is absent.

Test Plan:
1. Reset: rst_n low mid-ACCUM -> all outputs at reset values immediately; FSM=IDLE; no upd_pulse.
2. Frame with hits at (100,50), (300,50), (200,220) repeated until 64 hits, then frame_end -> 2 cycles later x_min=100, x_max=300, y_min=50, y_max=220, box_valid=1, upd_pulse for 1 cycle.
3. Frame with 63 hits -> box_valid=0; x_min..y_max=12'hFFF.
4. class_in=5 for 3 frames with STABLE_FRAMES=3 -> out_a stays 0 after frames 1-2, becomes 5 after frame 3; class_in=2 on frame 4 -> out_a stays 5.
5. Second frame_start before frame_end -> no commit; the box reflects only the hits after the second frame_start. Hit at (639,479) in the frame_start cycle -> counted. Hit at x=700 -> ignored.
6. BBOX_MARGIN_EN, MARGIN=4, hits spanning x=2..637, y=10..100 -> x_min=0, x_max=639, y_min=6, y_max=104.

Source files
------------

// File: rtl/bbox_overlay_ctrl.sv
// Per-frame bounding-box accumulator and class debouncer feeding the VGA overlay.
// Optional box expansion is enabled by defining BBOX_MARGIN_EN.
module bbox_overlay_ctrl #(
    parameter int unsigned H_DISP        = 640,
    parameter int unsigned V_DISP        = 480,
    parameter int unsigned MIN_HITS      = 64,
    parameter int unsigned HIT_CNT_W     = 20,
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned MARGIN        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        pix_valid,
    input  logic        pix_hit,
    input  logic [11:0] lcd_x,
    input  logic [11:0] lcd_y,
    input  logic        class_valid,
    input  logic [3:0]  class_in,
    output logic [11:0] x_min,
    output logic [11:0] x_max,
    output logic [11:0] y_min,
    output logic [11:0] y_max,
    output logic        box_valid,
    output logic [3:0]  out_a,
    output logic        upd_pulse
);

    localparam logic [11:0]          HDispW   = 12'(H_DISP);
    localparam logic [11:0]          VDispW   = 12'(V_DISP);
    localparam logic [11:0]          HMax     = 12'(H_DISP - 1);
    localparam logic [11:0]          VMax     = 12'(V_DISP - 1);
    localparam logic [HIT_CNT_W-1:0] MinHitsW = HIT_CNT_W'(MIN_HITS);
    localparam logic [3:0]           StableW  = 4'(STABLE_FRAMES);

    if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15 || MARGIN >= H_DISP || MARGIN >= V_DISP ||
        H_DISP > 4095 || V_DISP > 4095) begin : g_param_err
        $error("bbox_overlay_ctrl: invalid parameter set");
    end

    typedef enum logic [1:0] {StIdle, StAccum, StCommit} state_e;

    state_e state_q, state_d;

    logic [11:0]          xmin_acc_q, xmin_acc_d, xmax_acc_q, xmax_acc_d;
    logic [11:0]          ymin_acc_q, ymin_acc_d, ymax_acc_q, ymax_acc_d;
    logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic                 class_seen_q, class_seen_d;
    logic [3:0]           cand_new_q, cand_new_d, cand_prev_q, cand_prev_d;
    logic [3:0]           stable_cnt_q, stable_cnt_d;

    logic [11:0] x_min_q, x_min_d, x_max_q, x_max_d, y_min_q, y_min_d, y_max_q, y_max_d;
    logic        box_valid_q, box_valid_d, upd_pulse_q, upd_pulse_d;
    logic [3:0]  out_a_q, out_a_d;

    logic        pix_in, restart;
    logic [11:0] box_xmin, box_xmax, box_ymin, box_ymax;

    assign pix_in  = pix_valid & pix_hit & (lcd_x < HDispW) & (lcd_y < VDispW);
    // frame_start during COMMIT is dropped along with the state transition.
    assign restart = frame_start & (state_q != StCommit);

`ifdef BBOX_MARGIN_EN
    // Compare before subtracting/adding so the 12-bit result never wraps.
    localparam logic [11:0] MarginW = 12'(MARGIN);
    assign box_xmin = (xmin_acc_q < MarginW)        ? 12'd0 : xmin_acc_q - MarginW;
    assign box_xmax = (xmax_acc_q > HMax - MarginW) ? HMax  : xmax_acc_q + MarginW;
    assign box_ymin = (ymin_acc_q < MarginW)        ? 12'd0 : ymin_acc_q - MarginW;
    assign box_ymax = (ymax_acc_q > VMax - MarginW) ? VMax  : ymax_acc_q + MarginW;
`else
    assign box_xmin = xmin_acc_q;
    assign box_xmax = xmax_acc_q;
    assign box_ymin = ymin_acc_q;
    assign box_ymax = ymax_acc_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (frame_start) state_d = StAccum;
            StAccum:  if (!frame_start && frame_end) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Accumulator and class-capture next state.
    always_comb begin
        xmin_acc_d   = xmin_acc_q;
        xmax_acc_d   = xmax_acc_q;
        ymin_acc_d   = ymin_acc_q;
        ymax_acc_d   = ymax_acc_q;
        hit_cnt_d    = hit_cnt_q;
        class_seen_d = class_seen_q;
        cand_new_d   = cand_new_q;
        if (restart) begin
            class_seen_d = 1'b0;
            if (pix_in) begin
                xmin_acc_d = lcd_x;
                xmax_acc_d = lcd_x;
                ymin_acc_d = lcd_y;
                ymax_acc_d = lcd_y;
                hit_cnt_d  = HIT_CNT_W'(1);
            end else begin
                xmin_acc_d = HMax;
                xmax_acc_d = 12'd0;
                ymin_acc_d = VMax;
                ymax_acc_d = 12'd0;
                hit_cnt_d  = '0;
            end
        end else if (state_q == StAccum && pix_in) begin
            if (lcd_x < xmin_acc_q) xmin_acc_d = lcd_x;
            if (lcd_x > xmax_acc_q) xmax_acc_d = lcd_x;
            if (lcd_y < ymin_acc_q) ymin_acc_d = lcd_y;
            if (lcd_y > ymax_acc_q) ymax_acc_d = lcd_y;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
        end
        if (class_valid && class_in <= 4'd7) begin
            cand_new_d   = class_in;
            class_seen_d = 1'b1;
        end
    end

    // Committed outputs and debounce state; only move in the COMMIT cycle.
    always_comb begin
        x_min_d      = x_min_q;
        x_max_d      = x_max_q;
        y_min_d      = y_min_q;
        y_max_d      = y_max_q;
        box_valid_d  = box_valid_q;
        out_a_d      = out_a_q;
        cand_prev_d  = cand_prev_q;
        stable_cnt_d = stable_cnt_q;
        upd_pulse_d  = 1'b0;
        if (state_q == StCommit) begin
            upd_pulse_d = 1'b1;
            if (hit_cnt_q >= MinHitsW) begin
                box_valid_d = 1'b1;
                x_min_d     = box_xmin;
                x_max_d     = box_xmax;
                y_min_d     = box_ymin;
                y_max_d     = box_ymax;
            end else begin
                box_valid_d = 1'b0;
                x_min_d     = 12'hFFF;
                x_max_d     = 12'hFFF;
                y_min_d     = 12'hFFF;
                y_max_d     = 12'hFFF;
            end
            if (class_seen_q) begin
                if (cand_new_q == cand_prev_q) begin
                    stable_cnt_d = (stable_cnt_q == 4'd15) ? 4'd15 : stable_cnt_q + 4'd1;
                end else begin
                    stable_cnt_d = 4'd1;
                    cand_prev_d  = cand_new_q;
                end
            end else begin
                stable_cnt_d = 4'd0;
            end
            if (stable_cnt_d >= StableW) out_a_d = cand_prev_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin_acc_q   <= 12'd0;
            xmax_acc_q   <= 12'd0;
            ymin_acc_q   <= 12'd0;
            ymax_acc_q   <= 12'd0;
            hit_cnt_q    <= '0;
            class_seen_q <= 1'b0;
            cand_new_q   <= 4'd0;
            cand_prev_q  <= 4'd0;
            stable_cnt_q <= 4'd0;
            x_min_q      <= 12'hFFF;
            x_max_q      <= 12'hFFF;
            y_min_q      <= 12'hFFF;
            y_max_q      <= 12'hFFF;
            box_valid_q  <= 1'b0;
            out_a_q      <= 4'd0;
            upd_pulse_q  <= 1'b0;
        end else begin
            xmin_acc_q   <= xmin_acc_d;
            xmax_acc_q   <= xmax_acc_d;
            ymin_acc_q   <= ymin_acc_d;
            ymax_acc_q   <= ymax_acc_d;
            hit_cnt_q    <= hit_cnt_d;
            class_seen_q <= class_seen_d;
            cand_new_q   <= cand_new_d;
            cand_prev_q  <= cand_prev_d;
            stable_cnt_q <= stable_cnt_d;
            x_min_q      <= x_min_d;
            x_max_q      <= x_max_d;
            y_min_q      <= y_min_d;
            y_max_q      <= y_max_d;
            box_valid_q  <= box_valid_d;
            out_a_q      <= out_a_d;
            upd_pulse_q  <= upd_pulse_d;
        end
    end

    assign x_min     = x_min_q;
    assign x_max     = x_max_q;
    assign y_min     = y_min_q;
    assign y_max     = y_max_q;
    assign box_valid = box_valid_q;
    assign out_a     = out_a_q;
    assign upd_pulse = upd_pulse_q;

endmodule

// File: tb/tb_bbox_overlay_ctrl.sv
// Directed self-checking bench for bbox_overlay_ctrl; expectations follow BBOX_MARGIN_EN.
module tb_bbox_overlay_ctrl;

`ifdef BBOX_MARGIN_EN
    localparam int M = 4;
`else
    localparam int M = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, frame_start, frame_end, pix_valid, pix_hit, class_valid;
    logic [11:0] lcd_x, lcd_y;
    logic [3:0]  class_in;
    logic [11:0] x_min, x_max, y_min, y_max;
    logic        box_valid, upd_pulse;
    logic [3:0]  out_a;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bbox_overlay_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .pix_valid   (pix_valid),
        .pix_hit     (pix_hit),
        .lcd_x       (lcd_x),
        .lcd_y       (lcd_y),
        .class_valid (class_valid),
        .class_in    (class_in),
        .x_min       (x_min),
        .x_max       (x_max),
        .y_min       (y_min),
        .y_max       (y_max),
        .box_valid   (box_valid),
        .out_a       (out_a),
        .upd_pulse   (upd_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic hit, input logic [11:0] x, input logic [11:0] y);
        frame_start = 1'b1;
        pix_valid   = hit;
        pix_hit     = hit;
        lcd_x       = x;
        lcd_y       = y;
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_hit     = 1'b0;
    endtask

    task automatic pixels(input logic [11:0] x, input logic [11:0] y, input int n);
        pix_valid = 1'b1;
        pix_hit   = 1'b1;
        lcd_x     = x;
        lcd_y     = y;
        for (int i = 0; i < n; i++) tick();
        pix_valid = 1'b0;
        pix_hit   = 1'b0;
    endtask

    task automatic send_class(input logic [3:0] c);
        class_valid = 1'b1;
        class_in    = c;
        tick();
        class_valid = 1'b0;
    endtask

    // frame_end, then check the committed values two edges later.
    task automatic end_frame(input string tag, input logic [11:0] xmn, input logic [11:0] xmx,
                             input logic [11:0] ymn, input logic [11:0] ymx,
                             input logic bv, input logic [3:0] oa);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check({tag, "_pre_upd"}, upd_pulse, 0);
        tick();
        check({tag, "_upd"}, upd_pulse, 1);
        check({tag, "_xmin"}, x_min, xmn);
        check({tag, "_xmax"}, x_max, xmx);
        check({tag, "_ymin"}, y_min, ymn);
        check({tag, "_ymax"}, y_max, ymx);
        check({tag, "_bv"}, box_valid, bv);
        check({tag, "_outa"}, out_a, oa);
        tick();
        check({tag, "_upd_drop"}, upd_pulse, 0);
    endtask

    task automatic class_frame(input string tag, input logic [3:0] c, input logic [3:0] oa);
        start_frame(1'b0, 12'd0, 12'd0);
        send_class(c);
        end_frame(tag, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0, oa);
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0;
        pix_hit = 1'b0; lcd_x = '0; lcd_y = '0; class_valid = 1'b0; class_in = '0;
        tick();
        tick();
        check("rst_xmin", x_min, 12'hFFF);
        check("rst_bv", box_valid, 0);
        check("rst_outa", out_a, 0);
        check("rst_upd", upd_pulse, 0);
        rst_n = 1'b1;
        tick();

        // Three-point box with exactly MIN_HITS hits.
        start_frame(1'b0, 12'd0, 12'd0);
        for (int i = 0; i < 64; i++) begin
            case (i % 3)
                0:       pixels(12'd100, 12'd50, 1);
                1:       pixels(12'd300, 12'd50, 1);
                default: pixels(12'd200, 12'd220, 1);
            endcase
        end
        end_frame("box64", 12'(100 - M), 12'(300 + M), 12'(50 - M), 12'(220 + M), 1'b1, 4'd0);

        // One hit short of MIN_HITS.
        start_frame(1'b0, 12'd0, 12'd0);
        pixels(12'd10, 12'd20, 63);
        end_frame("box63", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0, 4'd0);

        // Class debounce; invalid class ignored, last valid pulse wins.
        class_frame("cls1", 4'd5, 4'd0);
        class_frame("cls2", 4'd5, 4'd0);
        class_frame("cls3", 4'd5, 4'd5);
        start_frame(1'b0, 12'd0, 12'd0);
        send_class(4'd2);
        send_class(4'd9);
        end_frame("cls4", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0, 4'd5);
        start_frame(1'b0, 12'd0, 12'd0);
        send_class(4'd7);
        send_class(4'd2);
        end_frame("cls5", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0, 4'd5);
        class_frame("cls6", 4'd2, 4'd2);

        // Restart mid-frame, frame_start-cycle hit counted, out-of-range hit ignored.
        start_frame(1'b0, 12'd0, 12'd0);
        pixels(12'd10, 12'd10, 64);
        start_frame(1'b1, 12'd639, 12'd479);
        check("restart_no_upd", upd_pulse, 0);
        pixels(12'd600, 12'd400, 63);
        pixels(12'd700, 12'd300, 1);
        check("restart_hold_xmin", x_min, 12'hFFF);
        end_frame("restart", 12'(600 - M), 12'd639, 12'(400 - M), 12'd479, 1'b1, 4'd2);

        // Asynchronous reset mid-frame.
        start_frame(1'b0, 12'd0, 12'd0);
        pixels(12'd5, 12'd5, 10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_xmin", x_min, 12'hFFF);
        check("mid_rst_xmax", x_max, 12'hFFF);
        check("mid_rst_ymin", y_min, 12'hFFF);
        check("mid_rst_ymax", y_max, 12'hFFF);
        check("mid_rst_bv", box_valid, 0);
        check("mid_rst_outa", out_a, 0);
        check("mid_rst_upd", upd_pulse, 0);
        rst_n = 1'b1;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        check("idle_fe_upd", upd_pulse, 0);
        tick();
        check("idle_fe_upd2", upd_pulse, 0);
        check("idle_fe_xmin", x_min, 12'hFFF);
        start_frame(1'b1, 12'd5, 12'd5);
        pixels(12'd5, 12'd5, 63);
        end_frame("post_rst", 12'(5 - M), 12'(5 + M), 12'(5 - M), 12'(5 + M), 1'b1, 4'd0);

        // Wide box hitting the clamp limits when the margin is enabled.
        start_frame(1'b1, 12'd2, 12'd10);
        pixels(12'd637, 12'd100, 63);
`ifdef BBOX_MARGIN_EN
        end_frame("wide", 12'd0, 12'd639, 12'd6, 12'd104, 1'b1, 4'd0);
`else
        end_frame("wide", 12'd2, 12'd637, 12'd10, 12'd100, 1'b1, 4'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
